// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op bit
// positions, FSM encodings, the iteration count and the final
// sign-correction / result-select helper.
// Optional build macro used by the sequencer: MULDIV_SHORTCUT_EN.
package muldiv_pkg;

  localparam int XLEN       = 32;
  localparam int ITER_COUNT = 32;

  // One-hot bit positions inside muldiv_info_i
  localparam int OP_MUL    = 0;
  localparam int OP_MULH   = 1;
  localparam int OP_MULHSU = 2;
  localparam int OP_MULHU  = 3;
  localparam int OP_DIV    = 4;
  localparam int OP_DIVU   = 5;
  localparam int OP_REM    = 6;
  localparam int OP_REMU   = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Turns the unsigned magnitude datapath result into the architectural
  // result: applies operand signs, forces the divide special cases and
  // picks the half / quotient / remainder the op asks for.
  function automatic logic [XLEN-1:0] finalize_result(
    input logic [7:0]      op,
    input logic            s1,
    input logic            s2,
    input logic [XLEN-1:0] hi,
    input logic [XLEN-1:0] lo,
    input logic [XLEN-1:0] rs1,
    input logic            div_zero,
    input logic            ovf
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic              psign;
    logic [XLEN-1:0]   res;
    psign = op[OP_MULHSU] ? s1 : (s1 ^ s2);
    prod  = psign ? -{hi, lo} : {hi, lo};
    quot  = (s1 ^ s2) ? -lo : lo;
    rem   = s1 ? -hi : hi;
    if (div_zero) begin
      quot = '1;
      rem  = rs1;
    end else if (ovf) begin
      quot = {1'b1, {(XLEN-1){1'b0}}};
      rem  = '0;
    end
    if (op[OP_MUL])
      res = prod[XLEN-1:0];
    else if (op[OP_MULH] | op[OP_MULHSU] | op[OP_MULHU])
      res = prod[2*XLEN-1:XLEN];
    else if (op[OP_DIV] | op[OP_DIVU])
      res = quot;
    else
      res = rem;
    return res;
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Execute-stage bundle between the core and the multiply/divide sequencer.
// The core side is the master; the sequencer is the slave.
interface muldiv_seq_if
  import muldiv_pkg::*;
();
  logic [7:0]      muldiv_info_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output muldiv_info_i, rs1_data_i, rs2_data_i,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  muldiv_info_i, rs1_data_i, rs2_data_i,
    output stall_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_iter.sv
// One iteration of the unsigned shift-add multiply or restoring divide.
// Both algorithms share a single 33-bit adder; {hi, lo} is the multiply
// accumulator or the {partial remainder, dividend/quotient} pair.
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] add_a;
  logic [XLEN:0] add_b;
  logic [XLEN:0] sum;
  logic          add_cin;

  // Shared adder: conditional add for multiply, trial subtract for divide
  always_comb begin
    if (is_div) begin
      add_a   = {hi, lo[XLEN-1]};
      add_b   = ~{1'b0, opb};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, hi};
      add_b   = lo[0] ? {1'b0, opb} : '0;
      add_cin = 1'b0;
    end
    sum = add_a + add_b + {{XLEN{1'b0}}, add_cin};
    if (is_div) begin
      if (!sum[XLEN]) begin
        hi_next = sum[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_next = add_a[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: latches a one-hot M-op, stalls the core
// for 32 iterations of muldiv_iter, then presents a one-cycle result.
// Build macro MULDIV_SHORTCUT_EN: trivially-known results (divide by zero,
// signed overflow, multiply by zero) skip the iterations.
module muldiv_seq
  import muldiv_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  muldiv_seq_if.slave bus
);

  state_t          state;
  logic [5:0]      cnt;
  logic [7:0]      op_q;
  logic            s1_q;
  logic            s2_q;
  logic            div_zero_q;
  logic            ovf_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] opb_q;
  logic [XLEN-1:0] rs1_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic            is_div_in;
  logic            s1_in;
  logic            s2_in;
  logic [XLEN-1:0] mag1_in;
  logic [XLEN-1:0] mag2_in;
  logic            div_zero_in;
  logic            ovf_in;
  logic            shortcut;
  logic            stall;
  logic [XLEN-1:0] hi_next;
  logic [XLEN-1:0] lo_next;
  logic [XLEN-1:0] fin_calc;
  logic [XLEN-1:0] fin_short;

  // Decode the incoming op: operand signs, magnitudes and special cases
  always_comb begin
    is_div_in = |bus.muldiv_info_i[OP_REMU:OP_DIV];
    s1_in = (bus.muldiv_info_i[OP_MUL] | bus.muldiv_info_i[OP_MULH] |
             bus.muldiv_info_i[OP_MULHSU] | bus.muldiv_info_i[OP_DIV] |
             bus.muldiv_info_i[OP_REM]) & bus.rs1_data_i[XLEN-1];
    s2_in = (bus.muldiv_info_i[OP_MUL] | bus.muldiv_info_i[OP_MULH] |
             bus.muldiv_info_i[OP_DIV] | bus.muldiv_info_i[OP_REM]) & bus.rs2_data_i[XLEN-1];
    mag1_in = s1_in ? -bus.rs1_data_i : bus.rs1_data_i;
    mag2_in = s2_in ? -bus.rs2_data_i : bus.rs2_data_i;
    div_zero_in = is_div_in & (bus.rs2_data_i == '0);
    ovf_in = (bus.muldiv_info_i[OP_DIV] | bus.muldiv_info_i[OP_REM]) &
             (bus.rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) & (bus.rs2_data_i == '1);
`ifdef MULDIV_SHORTCUT_EN
    shortcut = div_zero_in | ovf_in |
               (~is_div_in & ((bus.rs1_data_i == '0) | (bus.rs2_data_i == '0)));
`else
    shortcut = 1'b0;
`endif
  end

  muldiv_iter u_iter (
    .is_div  (|op_q[OP_REMU:OP_DIV]),
    .hi      (hi_q),
    .lo      (lo_q),
    .opb     (opb_q),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  // A shortcut result depends only on signs and forced values, so a zero
  // accumulator gives the same answer the full iteration would.
  assign fin_short = finalize_result(bus.muldiv_info_i, s1_in, s2_in, '0, '0,
                                     bus.rs1_data_i, div_zero_in, ovf_in);
  assign fin_calc  = finalize_result(op_q, s1_q, s2_q, hi_next, lo_next,
                                     rs1_q, div_zero_q, ovf_q);

  // Stall is combinational so the core freezes in the same cycle it issues
  always_comb begin
    case (state)
      IDLE:    stall = |bus.muldiv_info_i;
      CALC:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign bus.stall_o  = stall;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;

  // Sequencer FSM with iteration counter, datapath and registered result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      opb_q      <= '0;
      rs1_q      <= '0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q   <= 1'b0;
          result_q <= '0;
          if (|bus.muldiv_info_i) begin
            op_q       <= bus.muldiv_info_i;
            s1_q       <= s1_in;
            s2_q       <= s2_in;
            div_zero_q <= div_zero_in;
            ovf_q      <= ovf_in;
            rs1_q      <= bus.rs1_data_i;
            hi_q       <= '0;
            lo_q       <= is_div_in ? mag1_in : mag2_in;
            opb_q      <= is_div_in ? mag2_in : mag1_in;
            cnt        <= '0;
            if (shortcut) begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= fin_short;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          hi_q <= hi_next;
          lo_q <= lo_next;
          if (cnt == 6'(ITER_COUNT - 1)) begin
            state    <= DONE;
            done_q   <= 1'b1;
            result_q <= fin_calc;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          done_q   <= 1'b0;
          result_q <= '0;
        end
        default: begin
          state    <= IDLE;
          done_q   <= 1'b0;
          result_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vectors, randomized ops
// against an arithmetic reference model, reset behaviour, back-to-back
// issue and an illegal multi-hot op. Honours MULDIV_SHORTCUT_EN.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  logic [31:0] last_result;
  int          last_latency;
  int          last_stalls;
  int          last_done_cycle;
  bit          last_timeout;
  bit          last_overlap;
  bit          last_leak;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock and cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Absolute time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int          dir_op  [12] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_DIV, OP_REM,
                                OP_DIVU, OP_REMU, OP_DIVU, OP_REM, OP_DIV, OP_REM};
  logic [31:0] dir_a   [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                                32'h1234, 32'h1234, 32'h80000000, 32'h80000000};
  logic [31:0] dir_b   [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2,
                                32'd2, 32'd2, 32'd7, 32'd7,
                                32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] dir_exp [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                                32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'd0};

  // Architectural RV32M result from plain 64-bit arithmetic
  function automatic logic [31:0] ref_result(int op, logic [31:0] a, logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    logic [63:0] p;
    logic [31:0] r;
    bit          ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    r   = '0;
    case (op)
      OP_MUL:    begin p = sa * sb; r = p[31:0]; end
      OP_MULH:   begin p = sa * sb; r = p[63:32]; end
      OP_MULHSU: begin p = sa * $signed({32'b0, b}); r = p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      OP_DIV: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (ovf) r = 32'h80000000;
        else begin q = sa / sb; r = q[31:0]; end
      end
      OP_DIVU: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      OP_REM: begin
        if (b == 0) r = a;
        else if (ovf) r = 32'd0;
        else begin q = sa % sb; r = q[31:0]; end
      end
      OP_REMU: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Cycles from issue to done inclusive
  function automatic int exp_latency(int op, logic [31:0] a, logic [31:0] b);
    int lat;
    lat = 34;
`ifdef MULDIV_SHORTCUT_EN
    if (op >= OP_DIV && b == 0) lat = 2;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) lat = 2;
    if (op < OP_DIV && (a == 0 || b == 0)) lat = 2;
`endif
    return lat;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0;
      1:       v = 32'hFFFFFFFF;
      2:       v = 32'h80000000;
      3:       v = $urandom_range(0, 15);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one op (called at the drive point just after a rising edge), hold
  // it while stalled, record the outcome; returns at the next drive point.
  task automatic run_op(input logic [7:0] info, input logic [31:0] a, input logic [31:0] b);
    bit seen;
    seen = 0;
    last_stalls  = 0;
    last_overlap = 0;
    last_leak    = 0;
    last_latency = 0;
    last_result  = '0;
    bus.muldiv_info_i = info;
    bus.rs1_data_i    = a;
    bus.rs2_data_i    = b;
    #1;
    for (int k = 0; k < 64; k++) begin
      if (bus.stall_o) last_stalls++;
      if (bus.done_o) begin
        seen            = 1;
        last_overlap    = bus.stall_o;
        last_result     = bus.result_o;
        last_latency    = k + 1;
        last_done_cycle = cycle;
      end else if (bus.result_o !== 32'd0) begin
        last_leak = 1;
      end
      @(posedge clk);
      if (seen) break;
      #2;
    end
    #1;
    bus.muldiv_info_i = '0;
    last_timeout = !seen;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst_n = 1'b0;
    bus.muldiv_info_i = '0;
    bus.rs1_data_i    = '0;
    bus.rs2_data_i    = '0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (bus.done_o !== 1'b0 || bus.result_o !== 32'd0 || bus.stall_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: done=%b result=%h stall=%b, required 0/00000000/0",
               bus.done_o, bus.result_o, bus.stall_o);
    end
    bus.muldiv_info_i = 8'h01;
    bus.rs1_data_i    = 32'd5;
    bus.rs2_data_i    = 32'd7;
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_idle_stall: stall=%b, required 1", bus.stall_o);
    end
    @(posedge clk);
    #2;
    checks++;
    if (bus.done_o !== 1'b0 || bus.result_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_held: done=%b result=%h, required 0/00000000",
               bus.done_o, bus.result_o);
    end
    bus.muldiv_info_i = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    int lat;
    $display("[TB] test_directed");
    for (int i = 0; i < 12; i++) begin
      lat = exp_latency(dir_op[i], dir_a[i], dir_b[i]);
      run_op(8'b1 << dir_op[i], dir_a[i], dir_b[i]);
      checks++;
      if (last_result !== dir_exp[i]) begin
        errors++;
        $display("[TB] FAIL dir_result[%0d]: got %h, required %h", i, last_result, dir_exp[i]);
      end
      checks++;
      if (last_latency != lat || last_stalls != lat - 1) begin
        errors++;
        $display("[TB] FAIL dir_timing[%0d]: latency %0d stalls %0d, required %0d/%0d",
                 i, last_latency, last_stalls, lat, lat - 1);
      end
      checks++;
      if (last_timeout || last_overlap || last_leak) begin
        errors++;
        $display("[TB] FAIL dir_handshake[%0d]: timeout=%b overlap=%b leak=%b, required 0/0/0",
                 i, last_timeout, last_overlap, last_leak);
      end
    end
  endtask

  task automatic test_random();
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    $display("[TB] test_random");
    for (int i = 0; i < 48; i++) begin
      op  = $urandom_range(0, 7);
      a   = rand_operand();
      b   = rand_operand();
      exp = ref_result(op, a, b);
      lat = exp_latency(op, a, b);
      run_op(8'b1 << op, a, b);
      checks++;
      if (last_result !== exp) begin
        errors++;
        $display("[TB] FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h, required %h",
                 i, op, a, b, last_result, exp);
      end
      checks++;
      if (last_latency != lat || last_stalls != lat - 1 ||
          last_timeout || last_overlap || last_leak) begin
        errors++;
        $display("[TB] FAIL rand_timing[%0d]: latency %0d stalls %0d ovl=%b leak=%b, required %0d/%0d/0/0",
                 i, last_latency, last_stalls, last_overlap, last_leak, lat, lat - 1);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] a;
    logic [31:0] b;
    $display("[TB] test_reset_mid_op");
    bus.muldiv_info_i = 8'b1 << OP_MUL;
    bus.rs1_data_i    = $urandom | 32'd1;
    bus.rs2_data_i    = $urandom | 32'd1;
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if (bus.stall_o !== 1'b1 || bus.done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_calc: stall=%b done=%b, required 1/0", bus.stall_o, bus.done_o);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    bus.muldiv_info_i = '0;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.done_o !== 1'b0 || bus.result_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL midop_reset: stall=%b done=%b result=%h, required 0/0/00000000",
               bus.stall_o, bus.done_o, bus.result_o);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    a = $urandom | 32'd1;
    b = $urandom_range(1, 1000);
    run_op(8'b1 << OP_REMU, a, b);
    checks++;
    if (last_result !== a % b || last_latency != 34 || last_timeout) begin
      errors++;
      $display("[TB] FAIL midop_recover: result %h latency %0d, required %h/34",
               last_result, last_latency, a % b);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1;
    logic [31:0] b1;
    logic [31:0] a2;
    logic [31:0] b2;
    logic [31:0] r1;
    int          d1;
    $display("[TB] test_back_to_back");
    a1 = $urandom | 32'd1;
    b1 = $urandom | 32'd1;
    a2 = $urandom | 32'd1;
    b2 = $urandom_range(1, 5000);
    run_op(8'b1 << OP_MUL, a1, b1);
    r1 = last_result;
    d1 = last_done_cycle;
    run_op(8'b1 << OP_DIVU, a2, b2);
    checks++;
    if (r1 !== a1 * b1) begin
      errors++;
      $display("[TB] FAIL b2b_mul: got %h, required %h", r1, a1 * b1);
    end
    checks++;
    if (last_result !== a2 / b2) begin
      errors++;
      $display("[TB] FAIL b2b_divu: got %h, required %h", last_result, a2 / b2);
    end
    checks++;
    if (last_timeout || last_done_cycle - d1 != 34) begin
      errors++;
      $display("[TB] FAIL b2b_spacing: done pulses %0d cycles apart, required 34",
               last_done_cycle - d1);
    end
  endtask

  task automatic test_multi_hot();
    $display("[TB] test_multi_hot");
    run_op(8'b0001_0001, $urandom | 32'd1, $urandom | 32'd1);
    checks++;
    if (last_timeout || last_latency > 34) begin
      errors++;
      $display("[TB] FAIL multi_hot_return: latency %0d timeout=%b, required <=34/0",
               last_latency, last_timeout);
    end
    run_op(8'b1 << OP_DIVU, 32'd100, 32'd7);
    checks++;
    if (last_result !== 32'd14 || last_timeout) begin
      errors++;
      $display("[TB] FAIL multi_hot_after: got %h, required 0000000e", last_result);
    end
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_op();
    test_back_to_back();
    test_multi_hot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
